abacus_event_counter_bank: RTL and testbench
============================================

Name: abacus_event_counter_bank

Overview:
Parametrised, Wishbone-mapped bank of NUM_CHANNELS hardware event counters for the ABACUS profiler. It generalises the fixed instruction and cache counters into generic channels, and counts core events either per-cycle (latency) or per rising edge (occurrence). It adds counters wider than 32 bits, saturate/wrap overflow with sticky flags, and atomic snapshot of all counters. It sits beside the existing profilers on the same Wishbone slave bus.

Parameters:
BASE_ADDR, 32'hf0040000, byte base address of the register window
NUM_CHANNELS, 8, number of counter channels, 1..16
COUNTER_WIDTH, 48, counter width in bits, 1..64

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
wb_cyc  in  1  Wishbone cycle
wb_stb  in  1  Wishbone strobe
wb_we  in  1  write enable
wb_adr  in  32  byte address
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
wb_ack  out  1  acknowledge, registered
events  in  NUM_CHANNELS  event inputs, synchronous to clk
irq  out  1  overflow interrupt; present only with ABACUS_OVERFLOW_IRQ_EN

Behaviour:
- Reset (rst=0, async): all counters, shadows, edge history, CTRL, CH_ENABLE, MODE and OVERFLOW are 0; wb_ack=0; wb_dat_o=0; irq=0.
- Register map, offset from BASE_ADDR:
  - 0x00 CTRL: bit0 EN (global enable); bit1 SAT (1=saturate, 0=wrap); bit2 CLR (self-clearing, reads 0); bit3 SNAP (self-clearing, reads 0).
  - 0x04 CH_ENABLE: bit i enables channel i.
  - 0x08 OVERFLOW: sticky status, write-1-to-clear.
  - 0x0C MODE: bit i 0=level (count every cycle events[i]=1), 1=edge (count 0->1 transitions).
  - 0x10 IRQ_MASK: optional feature only.
  - 0x40+8*i: live counter i bits[31:0].
  - 0x44+8*i: live counter i bits[COUNTER_WIDTH-1:32], zero-extended; 0 if COUNTER_WIDTH<=32.
  - 0x100+8*i / 0x104+8*i: snapshot shadow i, low / high.
  - Counters and shadows are read-only; writes to them are ignored.
- Wishbone handshake:
  - wb_ack <= wb_cyc & wb_stb & ~wb_ack. Ack lasts one cycle, one cycle after the strobe. Back-to-back requests are acked every other cycle.
  - Writes take effect on the same edge as ack assertion.
  - Unmapped, or channel index >= NUM_CHANNELS: read returns 0, write is ignored, still acked.
  - Bits above NUM_CHANNELS in CH_ENABLE, MODE and OVERFLOW read 0.
- Counting:
  - Channel i increments by 1 per cycle when EN & CH_ENABLE[i] & qualify[i].
  - qualify = events[i] in level mode; events[i] & ~prev[i] in edge mode.
  - prev[i] <= events[i] every cycle, independent of enables.
- Disabling (EN=0 or CH_ENABLE[i]=0) holds the counter value. Only CLR or reset zeroes it.
- Overflow: an increment while the counter is all-ones sets OVERFLOW[i].
  - SAT=0: counter wraps to 0.
  - SAT=1: counter holds all-ones; OVERFLOW still sets.
- Simultaneous events:
  - CLR beats increment; the counter is 0 on the next cycle.
  - CLR also zeroes OVERFLOW.
  - A new overflow set beats a W1C in the same cycle.
- SNAP: on the write edge, every shadow captures its live counter value before that edge's increment.
  - SNAP+CLR in one write: shadows get the pre-clear values.
- A Wishbone cycle aborted (wb_stb drops before ack) has no effect.
- Reset mid-transaction: wb_ack drops immediately.

Optional Feature:
ABACUS_OVERFLOW_IRQ_EN
- Defined:
  - Adds the irq port and IRQ_MASK at 0x10 (NUM_CHANNELS bits, reset 0).
  - irq <= |(OVERFLOW & IRQ_MASK), registered. It stays asserted until the flags are cleared by W1C or CLR.
- Undefined:
  - No irq port; IRQ_MASK logic is absent.
  - 0x10 reads 0 and writes are ignored.

Test Plan:
- Write CH_ENABLE=0x3, MODE=0x2, CTRL=0x1. Hold events[0]=1 for 5 cycles; pulse events[1] high 3 times, 2 cycles each. Read 0x40 -> 5; read 0x48 -> 3.
- With COUNTER_WIDTH=48 and SAT=0: drive ch0 to 0xFFFF_FFFF, then 1 more event. Read 0x40 -> 0, 0x44 -> 1, OVERFLOW -> 0.
- With COUNTER_WIDTH=8:
  - SAT=0: 256 level cycles -> count 0, OVERFLOW[0]=1.
  - SAT=1: repeat -> count 0xFF.
  - W1C 0x1 -> OVERFLOW 0.
- Count ch0 to 10, write CTRL=0xD (EN|CLR|SNAP). Read 0x100 -> 10; read 0x40 -> 0 or increments since clear; CTRL reads 0x1.
- Count ch0 to 7, write CTRL=0 and hold events high 20 cycles -> read 7; unmapped read 0x3FC -> 0 with ack. Back-to-back stb -> ack pulses every other cycle.
- ABACUS_OVERFLOW_IRQ_EN: IRQ_MASK=0x1 with 8-bit overflow -> irq=1 one cycle after the flag sets; W1C -> irq=0. Assert rst=0 mid-count -> all registers and irq 0 immediately.

Source files
------------

// File: rtl/abacus_event_counter_bank.sv
// ABACUS profiler event counter bank: Wishbone-mapped level/edge counters with
// wrap/saturate overflow, sticky flags and atomic snapshot. Optional: ABACUS_OVERFLOW_IRQ_EN.
module abacus_event_counter_bank #(
  parameter logic [31:0] BASE_ADDR     = 32'hf0040000,
  parameter int unsigned NUM_CHANNELS  = 8,
  parameter int unsigned COUNTER_WIDTH = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [31:0]             wb_adr,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack,
  input  logic [NUM_CHANNELS-1:0] events
`ifdef ABACUS_OVERFLOW_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int unsigned N = NUM_CHANNELS;
  localparam int unsigned W = COUNTER_WIDTH;
  typedef logic [W-1:0] cnt_t;

  logic         en, sat;
  logic [N-1:0] ch_en, mode, ovf, prev;
  cnt_t         cnt    [N];
  cnt_t         shadow [N];

  logic         req, wr, rd, ctrl_wr, clr, snap;
  logic [31:0]  off, rdata;
  logic [N-1:0] qual, inc, ovf_set, w1c;
  logic [3:0]   live_idx, shd_idx;
  logic [63:0]  live_val, shd_val;
  logic         unused_dat;

  assign req      = wb_cyc & wb_stb & ~wb_ack;
  assign wr       = req & wb_we;
  assign rd       = req & ~wb_we;
  assign off      = wb_adr - BASE_ADDR;
  assign ctrl_wr  = wr && (off == 32'h0);
  assign clr      = ctrl_wr & wb_dat_i[2];
  assign snap     = ctrl_wr & wb_dat_i[3];
  assign w1c      = (wr && (off == 32'h8)) ? wb_dat_i[N-1:0] : '0;
  assign unused_dat = ^wb_dat_i;

  // Edge mode suppresses the count while the event was already high last cycle.
  assign qual = events & ~(mode & prev);
  assign inc  = {N{en}} & ch_en & qual;

  always_comb begin
    ovf_set = '0;
    for (int unsigned i = 0; i < N; i++)
      ovf_set[i] = inc[i] && (cnt[i] == '1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (snap)
          shadow[i] <= cnt[i];
        if (clr)
          cnt[i] <= '0;
        else if (inc[i]) begin
          if (ovf_set[i])
            cnt[i] <= sat ? '1 : '0;
          else
            cnt[i] <= cnt[i] + cnt_t'(1);
        end
      end
    end
  end

`ifdef ABACUS_OVERFLOW_IRQ_EN
  logic [N-1:0] irq_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      irq <= |(ovf & irq_mask);
      if (wr && (off == 32'h10))
        irq_mask <= wb_dat_i[N-1:0];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en       <= 1'b0;
      sat      <= 1'b0;
      ch_en    <= '0;
      mode     <= '0;
      ovf      <= '0;
      prev     <= '0;
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack   <= req;
      wb_dat_o <= rd ? rdata : '0;
      prev     <= events;
      // A flag set this cycle survives a simultaneous W1C; CLR wins over both.
      ovf      <= clr ? '0 : ((ovf & ~w1c) | ovf_set);
      if (ctrl_wr) begin
        en  <= wb_dat_i[0];
        sat <= wb_dat_i[1];
      end
      if (wr && (off == 32'h4))
        ch_en <= wb_dat_i[N-1:0];
      if (wr && (off == 32'hC))
        mode <= wb_dat_i[N-1:0];
    end
  end

  assign live_idx = 4'((off - 32'h40) >> 3);
  assign shd_idx  = 4'((off - 32'h100) >> 3);

  always_comb begin
    live_val = '0;
    shd_val  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (live_idx == 4'(i)) live_val = 64'(cnt[i]);
      if (shd_idx == 4'(i))  shd_val  = 64'(shadow[i]);
    end
  end

  always_comb begin
    rdata = '0;
    if (off == 32'h0)
      rdata = {30'd0, sat, en};
    else if (off == 32'h4)
      rdata = 32'(ch_en);
    else if (off == 32'h8)
      rdata = 32'(ovf);
    else if (off == 32'hC)
      rdata = 32'(mode);
`ifdef ABACUS_OVERFLOW_IRQ_EN
    else if (off == 32'h10)
      rdata = 32'(irq_mask);
`endif
    else if (off >= 32'h40 && off < 32'h40 + 32'(8 * N))
      rdata = off[2] ? live_val[63:32] : live_val[31:0];
    else if (off >= 32'h100 && off < 32'h100 + 32'(8 * N))
      rdata = off[2] ? shd_val[63:32] : shd_val[31:0];
  end

endmodule

// File: tb/tb_abacus_event_counter_bank.sv
// Bench for abacus_event_counter_bank: a 48-bit and an 8-bit bank share one bus and
// event stream and are checked against a cycle-level behavioural model.
module tb_abacus_event_counter_bank;
  localparam logic [31:0] BASE = 32'hf0040000;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [31:0] adr, dat_i;
  logic [7:0]  events;
  logic [31:0] dat_o [2];
  logic        ack_o [2];
`ifdef ABACUS_OVERFLOW_IRQ_EN
  logic        irq_o [2];
`endif

  always #5 clk = ~clk;

  abacus_event_counter_bank #(.BASE_ADDR(BASE), .NUM_CHANNELS(8), .COUNTER_WIDTH(48)) u_big (
    .clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_dat_i(dat_i), .wb_dat_o(dat_o[0]), .wb_ack(ack_o[0]), .events(events)
`ifdef ABACUS_OVERFLOW_IRQ_EN
    , .irq(irq_o[0])
`endif
  );

  abacus_event_counter_bank #(.BASE_ADDR(BASE), .NUM_CHANNELS(8), .COUNTER_WIDTH(8)) u_small (
    .clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_dat_i(dat_i), .wb_dat_o(dat_o[1]), .wb_ack(ack_o[1]), .events(events)
`ifdef ABACUS_OVERFLOW_IRQ_EN
    , .irq(irq_o[1])
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference state, one set of counters per instance (index 0: 48-bit, 1: 8-bit).
  bit              m_en, m_sat, m_ack;
  bit [7:0]        m_chen, m_mode, m_prev, m_mask;
  bit [7:0]        m_ovf [2];
  bit              m_irq [2];
  longint unsigned m_cnt [2][8];
  longint unsigned m_shd [2][8];
  longint unsigned m_max [2] = '{64'hFFFF_FFFF_FFFF, 64'hFF};
  logic [31:0]     m_rd  [2];

  logic [31:0] rd_got [2];
  logic [31:0] rd_exp [2];
  logic        rd_ack [2];

  task automatic model_reset();
    m_en = 0; m_sat = 0; m_ack = 0; m_chen = 0; m_mode = 0; m_prev = 0; m_mask = 0;
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 0; m_irq[k] = 0; m_rd[k] = 0;
      for (int i = 0; i < 8; i++) begin m_cnt[k][i] = 0; m_shd[k][i] = 0; end
    end
  endtask

  function automatic logic [31:0] mread(int k, logic [31:0] off);
    longint unsigned v;
    int ch;
    if (off == 32'h0)  return {30'd0, m_sat, m_en};
    if (off == 32'h4)  return {24'd0, m_chen};
    if (off == 32'h8)  return {24'd0, m_ovf[k]};
    if (off == 32'hC)  return {24'd0, m_mode};
    if (off == 32'h10) begin
`ifdef ABACUS_OVERFLOW_IRQ_EN
      return {24'd0, m_mask};
`else
      return 32'd0;
`endif
    end
    if (off >= 32'h40 && off < 32'h80) begin
      ch = int'((off - 32'h40) >> 3);
      v  = m_cnt[k][ch];
      return (off[2]) ? v[63:32] : v[31:0];
    end
    if (off >= 32'h100 && off < 32'h140) begin
      ch = int'((off - 32'h100) >> 3);
      v  = m_shd[k][ch];
      return (off[2]) ? v[63:32] : v[31:0];
    end
    return 32'd0;
  endfunction

  // One clock edge: the model applies the same edge using the inputs held before it.
  task automatic tick();
    bit          req, wr, clr, snap, irqn;
    logic [31:0] off;
    bit [7:0]    w1c, setb;
    @(posedge clk);
    req  = cyc && stb && !m_ack;
    wr   = req && we;
    off  = adr - BASE;
    clr  = wr && off == 0 && dat_i[2];
    snap = wr && off == 0 && dat_i[3];
    w1c  = (wr && off == 32'h8) ? dat_i[7:0] : 8'h0;
    for (int k = 0; k < 2; k++) begin
      m_rd[k] = (req && !we) ? mread(k, off) : 32'd0;
      irqn = |(m_ovf[k] & m_mask);
      setb = 0;
      for (int i = 0; i < 8; i++) begin
        if (snap) m_shd[k][i] = m_cnt[k][i];
        if (clr) m_cnt[k][i] = 0;
        else if (m_en && m_chen[i] && events[i] && !(m_mode[i] && m_prev[i])) begin
          if (m_cnt[k][i] == m_max[k]) begin
            setb[i] = 1;
            m_cnt[k][i] = m_sat ? m_max[k] : 0;
          end else m_cnt[k][i]++;
        end
      end
      m_ovf[k] = clr ? 8'h0 : ((m_ovf[k] & ~w1c) | setb);
      m_irq[k] = irqn;
    end
    if (wr) begin
      if (off == 32'h0) begin m_en = dat_i[0]; m_sat = dat_i[1]; end
      if (off == 32'h4) m_chen = dat_i[7:0];
      if (off == 32'hC) m_mode = dat_i[7:0];
`ifdef ABACUS_OVERFLOW_IRQ_EN
      if (off == 32'h10) m_mask = dat_i[7:0];
`endif
    end
    m_prev = events;
    m_ack  = req;
    #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    cyc = 1; stb = 1; we = 1; adr = BASE + a; dat_i = d;
    tick();
    cyc = 0; stb = 0; we = 0;
    tick();
  endtask

  task automatic wb_read(input logic [31:0] a);
    cyc = 1; stb = 1; we = 0; adr = BASE + a;
    tick();
    for (int k = 0; k < 2; k++) begin
      rd_got[k] = dat_o[k]; rd_ack[k] = ack_o[k]; rd_exp[k] = m_rd[k];
    end
    cyc = 0; stb = 0;
    tick();
  endtask

  task automatic run_events(input logic [7:0] ev, input int n);
    events = ev;
    repeat (n) tick();
    events = 8'h0;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ack_o[k] !== 1'b0 || dat_o[k] !== 32'h0) begin
        bad++; $display("FAIL reset_outputs inst%0d ack=%b dat=%h required ack=0 dat=0", k, ack_o[k], dat_o[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    foreach (rd_exp[j]) ;
    for (int a = 0; a <= 5; a++) begin
      wb_read(a < 4 ? 32'(a * 4) : (a == 4 ? 32'h40 : 32'h100));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd_got[k] !== 32'h0 || rd_ack[k] !== 1'b1) begin
          bad++; $display("FAIL reset_reg%0d inst%0d got=%h ack=%b required=0 ack=1", a, k, rd_got[k], rd_ack[k]);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] req_v [2];
    wb_write(32'h4, 32'h3);
    wb_write(32'hC, 32'h2);
    wb_write(32'h0, 32'h1);
    run_events(8'h01, 5);
    repeat (3) begin run_events(8'h02, 2); tick(); tick(); end
    for (int r = 0; r < 2; r++) begin
      wb_read(r == 0 ? 32'h40 : 32'h48);
      req_v[0] = (r == 0) ? 32'd5 : 32'd3;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd_got[k] !== req_v[0] || rd_ack[k] !== 1'b1) begin
          bad++; $display("FAIL basic_ch%0d inst%0d got=%0d ack=%b required=%0d", r, k, rd_got[k], rd_ack[k], req_v[0]);
        end
      end
    end
  endtask

  task automatic test_random();
    wb_write(32'h0, 32'h5 | ($urandom_range(0, 1) << 1));
    wb_write(32'h4, $urandom_range(0, 255));
    wb_write(32'hC, $urandom_range(0, 255));
    for (int c = 0; c < 400; c++) begin
      events = 8'($urandom);
      if (c == 200) begin
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h8; dat_i = $urandom_range(0, 255);
        tick();
        cyc = 0; stb = 0; we = 0;
      end
      tick();
    end
    events = 8'h0;
    for (int a = 0; a < 18; a++) begin
      wb_read(a < 16 ? 32'h40 + 32'(a * 4) : (a == 16 ? 32'h8 : 32'h0));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd_got[k] !== rd_exp[k] || rd_ack[k] !== 1'b1) begin
          bad++; $display("FAIL random_rd%0d inst%0d got=%h ack=%b required=%h", a, k, rd_got[k], rd_ack[k], rd_exp[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] req_v [2];
    wb_write(32'h0, 32'h5);
    wb_write(32'h4, 32'h1);
    wb_write(32'hC, 32'h0);
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 1) wb_write(32'h0, 32'h3);
      if (ph < 2) run_events(8'h01, 256);
      if (ph == 2) wb_write(32'h8, 32'h1);
      for (int r = 0; r < 2; r++) begin
        wb_read(r == 0 ? 32'h40 : 32'h8);
        if (r == 0) begin req_v[0] = (ph == 0) ? 32'd256 : 32'd512; req_v[1] = (ph == 0) ? 32'd0 : 32'hFF; end
        else        begin req_v[0] = 32'd0; req_v[1] = (ph == 2) ? 32'd0 : 32'd1; end
        for (int k = 0; k < 2; k++) begin
          total++;
          if (rd_got[k] !== req_v[k]) begin
            bad++; $display("FAIL overflow_p%0d_r%0d inst%0d got=%h required=%h", ph, r, k, rd_got[k], req_v[k]);
          end
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] req_v;
    wb_write(32'h0, 32'h5);
    wb_write(32'h4, 32'h1);
    run_events(8'h01, 10);
    wb_write(32'h0, 32'hD);
    for (int r = 0; r < 3; r++) begin
      wb_read(r == 0 ? 32'h100 : (r == 1 ? 32'h40 : 32'h0));
      req_v = (r == 0) ? 32'd10 : (r == 1 ? 32'd0 : 32'd1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd_got[k] !== req_v) begin
          bad++; $display("FAIL snapshot_r%0d inst%0d got=%h required=%h", r, k, rd_got[k], req_v);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] addrs [5] = '{32'h40, 32'h40, 32'h3FC, 32'h80, 32'h10};
    logic [31:0] req_v;
    wb_write(32'h0, 32'h5);
    run_events(8'h01, 7);
    wb_write(32'h0, 32'h0);
    events = 8'hFF;
    repeat (20) tick();
    for (int r = 0; r < 5; r++) begin
      if (r == 1) wb_write(32'h40, 32'h1234);
      wb_read(addrs[r]);
      req_v = (r < 2) ? 32'd7 : 32'd0;
`ifdef ABACUS_OVERFLOW_IRQ_EN
      if (r == 4) req_v = {24'd0, m_mask};
`endif
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd_got[k] !== req_v || rd_ack[k] !== 1'b1) begin
          bad++; $display("FAIL hold_r%0d inst%0d got=%h ack=%b required=%h ack=1", r, k, rd_got[k], rd_ack[k], req_v);
        end
      end
    end
    events = 8'h0;
  endtask

  task automatic test_back_to_back();
    cyc = 1; stb = 1; we = 0; adr = BASE;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (ack_o[k] !== ((c % 2) == 0)) begin
          bad++; $display("FAIL b2b_ack_c%0d inst%0d got=%b required=%b", c, k, ack_o[k], (c % 2) == 0);
        end
      end
    end
    cyc = 0; stb = 0;
    tick();
  endtask

  task automatic test_abort();
    cyc = 1; stb = 1; we = 1; adr = BASE; dat_i = 32'h3;
    #3;
    cyc = 0; stb = 0; we = 0;
    tick();
    wb_read(32'h0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rd_got[k] !== 32'h0) begin
        bad++; $display("FAIL abort_ctrl inst%0d got=%h required=0", k, rd_got[k]);
      end
    end
  endtask

`ifdef ABACUS_OVERFLOW_IRQ_EN
  task automatic test_irq();
    wb_write(32'h0, 32'h5);
    wb_write(32'h4, 32'h1);
    wb_write(32'h10, 32'h1);
    run_events(8'h01, 255);
    events = 8'h01;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin tick(); events = 8'h0; end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (irq_o[k] !== (k == 1 && c == 2)) begin
          bad++; $display("FAIL irq_c%0d inst%0d got=%b required=%b", c, k, irq_o[k], k == 1 && c == 2);
        end
      end
    end
    wb_write(32'h8, 32'h1);
    total++;
    if (irq_o[1] !== 1'b0) begin
      bad++; $display("FAIL irq_w1c got=%b required=0", irq_o[1]);
    end
    run_events(8'h01, 256);
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    wb_write(32'h0, 32'h5);
    wb_write(32'h4, 32'hFF);
    run_events(8'hFF, 20);
    events = 8'hFF;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h40;
    tick();
    #2 rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ack_o[k] !== 1'b0 || dat_o[k] !== 32'h0) begin
        bad++; $display("FAIL midreset_out inst%0d ack=%b dat=%h required ack=0 dat=0", k, ack_o[k], dat_o[k]);
      end
`ifdef ABACUS_OVERFLOW_IRQ_EN
      total++;
      if (irq_o[k] !== 1'b0) begin
        bad++; $display("FAIL midreset_irq inst%0d got=%b required=0", k, irq_o[k]);
      end
`endif
    end
    model_reset();
    cyc = 0; stb = 0; events = 8'h0;
    #1 rst = 1;
    tick();
    for (int r = 0; r < 3; r++) begin
      wb_read(r == 0 ? 32'h40 : (r == 1 ? 32'h0 : 32'h4));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd_got[k] !== 32'h0) begin
          bad++; $display("FAIL midreset_r%0d inst%0d got=%h required=0", r, k, rd_got[k]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; dat_i = 0; events = 0;
    model_reset();
    #2 rst = 0;
    test_reset();
    test_basic();
    test_random();
    test_overflow();
    test_snapshot();
    test_hold();
    test_back_to_back();
    test_abort();
`ifdef ABACUS_OVERFLOW_IRQ_EN
    test_irq();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
